lambda2_inverse_permuter: RTL and testbench



---
 rtl/osd_pkg.sv | 19 +
 rtl/lambda2_inverse_permuter.sv | 165 ++++++++++++++++
 tb/tb_lambda2_inverse_permuter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/osd_pkg.sv
// Shared OSD definitions: FSM state encoding, default code dimensions and an
// index-width helper used by the permutation stages.
package osd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCATTER = 2'd1,
    ST_DONE    = 2'd2
  } osd_state_e;

  localparam int unsigned OSD_N_DEF = 8;
  localparam int unsigned OSD_K_DEF = 4;

  // Width of one column index; never below 1 so degenerate N still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lambda2_inverse_permuter.sv
// Inverse column permuter for the OSD decoder: scatters a permuted codeword back to
// original column order, one index per clock, and builds lambda2^-1. Optional
// malformed-permutation detection is compiled in with `define PERM_CHECK_EN.
module lambda2_inverse_permuter
  import osd_pkg::*;
#(
  parameter int unsigned N     = OSD_N_DEF,
  parameter int unsigned K     = OSD_K_DEF,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*IDX_W-1:0] lambda2_flat,
  input  logic [N-1:0]       cw_perm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       cw_orig,
  output logic [N*IDX_W-1:0] inv_lambda2_flat,
  output logic               busy
`ifdef PERM_CHECK_EN
  ,
  output logic               perm_err
`endif
);

  localparam int unsigned    CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // K only describes the code; an empty scope marks a configuration with K > N.
  if (K > N) begin : g_k_exceeds_n
  end

  osd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  lam_q [N];
  logic [IDX_W-1:0]  lam_d [N];
  logic [N-1:0]      cwp_q, cwp_d;
  logic [N-1:0]      cw_orig_q, cw_orig_d;
  logic [IDX_W-1:0]  inv_q [N];
  logic [IDX_W-1:0]  inv_d [N];

  logic [IDX_W-1:0]  cur_idx;
  logic              cur_bit;
  logic              idx_ok;

  assign cur_idx = lam_q[cnt_q[IDX_W-1:0]];
  assign cur_bit = cwp_q[cnt_q[IDX_W-1:0]];
  assign idx_ok  = (32'(cur_idx) < N);

`ifdef PERM_CHECK_EN
  logic [N-1:0] seen_q, seen_d;
  logic         perm_err_q, perm_err_d;
`endif

  // NOTE: all state is written with <= here; the comb block below uses = only.
  // NOTE: the index arrays are reset too, so a fresh result can never expose
  // values left over from an aborted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cwp_q     <= '0;
      cw_orig_q <= '0;
      for (int i = 0; i < N; i++) begin
        lam_q[i] <= '0;
        inv_q[i] <= '0;
      end
`ifdef PERM_CHECK_EN
      seen_q     <= '0;
      perm_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cwp_q     <= cwp_d;
      cw_orig_q <= cw_orig_d;
      lam_q     <= lam_d;
      inv_q     <= inv_d;
`ifdef PERM_CHECK_EN
      seen_q     <= seen_d;
      perm_err_q <= perm_err_d;
`endif
    end
  end

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cwp_d     = cwp_q;
    cw_orig_d = cw_orig_q;
    lam_d     = lam_q;
    inv_d     = inv_q;
`ifdef PERM_CHECK_EN
    seen_d     = seen_q;
    perm_err_d = perm_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N; i++) begin
            lam_d[i] = lambda2_flat[i*IDX_W +: IDX_W];
            inv_d[i] = '0;
          end
          cwp_d     = cw_perm;
          cw_orig_d = '0;
          cnt_d     = '0;
          state_d   = ST_SCATTER;
`ifdef PERM_CHECK_EN
          seen_d     = '0;
          perm_err_d = 1'b0;
`endif
        end
      end

      ST_SCATTER: begin
        // Later positions overwrite earlier ones on duplicate indices.
        if (idx_ok) begin
          cw_orig_d[cur_idx] = cur_bit;
          inv_d[cur_idx]     = cnt_q[IDX_W-1:0];
        end
`ifdef PERM_CHECK_EN
        if (!idx_ok || seen_q[cur_idx]) begin
          perm_err_d = 1'b1;
        end
        if (idx_ok) begin
          seen_d[cur_idx] = 1'b1;
        end
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign cw_orig   = cw_orig_q;

  always_comb begin
    inv_lambda2_flat = '0;
    for (int i = 0; i < N; i++) begin
      inv_lambda2_flat[i*IDX_W +: IDX_W] = inv_q[i];
    end
  end

`ifdef PERM_CHECK_EN
  assign perm_err = perm_err_q;
`endif

endmodule

// File: tb/tb_lambda2_inverse_permuter.sv
// Self-checking bench for lambda2_inverse_permuter: table-driven vectors with a
// scoreboard queue, plus hand-written backpressure, reset and back-to-back sequences.
module tb_lambda2_inverse_permuter;

  localparam int N = 8;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] lambda2_flat;
  logic [N-1:0]   cw_perm;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   cw_orig;
  logic [N*W-1:0] inv_lambda2_flat;
  logic           busy;
`ifdef PERM_CHECK_EN
  logic           perm_err;
`endif

  lambda2_inverse_permuter #(.N(N), .K(4), .IDX_W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .lambda2_flat     (lambda2_flat),
    .cw_perm          (cw_perm),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .cw_orig          (cw_orig),
    .inv_lambda2_flat (inv_lambda2_flat),
    .busy             (busy)
`ifdef PERM_CHECK_EN
    ,
    .perm_err         (perm_err)
`endif
  );

  always #5 clk = ~clk;

  typedef logic [W-1:0] perm_t [N];

  typedef struct {
    perm_t        lam;
    logic [N-1:0] cw;
    logic [N-1:0] exp_cw;
    perm_t        exp_inv;
    logic         exp_err;
    int           hold;
  } vec_t;

  typedef struct {
    logic [N-1:0]   cw;
    logic [N*W-1:0] inv;
    logic           err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [N*W-1:0] pack(input perm_t p);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = p[i];
    return r;
  endfunction

  // Reference model: cw_orig[lam[i]] = cw[i], inv[lam[i]] = i, last write wins.
  function automatic vec_t model(input perm_t lam, input logic [N-1:0] cw, input int hold);
    vec_t         v;
    logic [N-1:0] seen;
    v.lam = lam; v.cw = cw; v.hold = hold;
    v.exp_cw = '0; v.exp_err = 1'b0; seen = '0;
    for (int i = 0; i < N; i++) v.exp_inv[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (seen[lam[i]]) v.exp_err = 1'b1;
      seen[lam[i]]       = 1'b1;
      v.exp_cw[lam[i]]   = cw[i];
      v.exp_inv[lam[i]]  = W'(i);
    end
    return v;
  endfunction

  function automatic perm_t shuffle();
    perm_t p;
    logic [W-1:0] t;
    int j;
    for (int i = 0; i < N; i++) p[i] = W'(i);
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid     = 1'b1;
    lambda2_flat = pack(v.lam);
    cw_perm      = v.cw;
  endtask

  task automatic accept(input vec_t v);
    int t;
    t = 0;
    drive(v);
    while (!in_ready && t < 40) begin
      step();
      t++;
    end
    check("accept_wait_ok", 64'(t < 40), 64'd1);
    step();
    in_valid = 1'b0;
    sb.push_back('{v.exp_cw, pack(v.exp_inv), v.exp_err});
  endtask

  task automatic collect(input int hold);
    int             lat;
    exp_t           e;
    logic [N-1:0]   cw0;
    logic [N*W-1:0] inv0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check("latency", 64'(lat), 64'(N));
    cw0  = cw_orig;
    inv0 = inv_lambda2_flat;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_stable", {out_valid, in_ready, busy, cw_orig, inv_lambda2_flat},
            {1'b1, 1'b0, 1'b1, cw0, inv0});
    end
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("cw_orig", 64'(cw_orig), 64'(e.cw));
      check("inv_lambda2", 64'(inv_lambda2_flat), 64'(e.inv));
`ifdef PERM_CHECK_EN
      check("perm_err", 64'(perm_err), 64'(e.err));
`endif
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_handshake", {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    vec_t v, v2;
    bit   saw_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    lambda2_flat = '0; cw_perm = '0;

    // Spec vectors with hand-derived expectations, then random permutations via model.
    vecs.push_back('{'{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd5, 3'd7}, 8'h0F, 8'h5A,
                     '{3'd4, 3'd0, 3'd5, 3'd1, 3'd2, 3'd6, 3'd3, 3'd7}, 1'b0, 0});
    vecs.push_back('{'{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8'h01, 8'h80,
                     '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 1});
    vecs.push_back('{'{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 8'hA5, 8'hA5,
                     '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 1'b0, 5});
    vecs.push_back('{'{3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 8'h01, 8'h00,
                     '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 1'b1, 0});
    vecs.push_back('{'{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5}, 8'h7F, 8'h00,
                     '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0}, 1'b1, 2});
    for (int r = 0; r < 3; r++) vecs.push_back(model(shuffle(), 8'($urandom), r));

    #12;
    check("reset_state", {in_ready, out_valid, busy, cw_orig, inv_lambda2_flat},
          {1'b1, 1'b0, 1'b0, 8'h00, 24'h0});
    rst = 1'b0;
    step();

    foreach (vecs[k]) begin
      accept(vecs[k]);
      collect(vecs[k].hold);
    end

    // Reset pulsed mid-SCATTER: asynchronous return to reset values, no out_valid.
    v = model(shuffle(), 8'hC3, 0);
    accept(v);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("async_reset", {in_ready, out_valid, busy, cw_orig, inv_lambda2_flat},
          {1'b1, 1'b0, 1'b0, 8'h00, 24'h0});
    void'(sb.pop_back());
    #2 rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    check("no_valid_after_reset", 64'(saw_valid), 64'd0);
    v = model(shuffle(), 8'h3C, 1);
    accept(v);
    collect(v.hold);

    // Back-to-back: second request held valid during SCATTER must wait for IDLE.
    v  = model(shuffle(), 8'h96, 0);
    v2 = model(shuffle(), 8'h69, 0);
    accept(v);
    drive(v2);
    collect(2);
    accept(v2);
    collect(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
